// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_pkg
// Description : Shared types and constants for the system output scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DWELL  = 2'd3
    } state_t;

    localparam int c_LED_W = 27;
    localparam int c_SEL_W = 8;
    localparam int c_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/sys_load_counter.sv
`default_nettype none
// ============================================================================
// Module      : sys_load_counter
// Description : Loadable down-counter with decrement enable and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_load_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sys_output_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sys_output_scanner
// Description : Round-robin sweep of the system output select with settle,
//               sample and dwell phases; publishes each captured LED word.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_output_scanner
    import sys_pkg::*;
#(
    parameter int NUM_SEL = 8,
    parameter int LED_W   = c_LED_W,
    parameter int SETTLE  = 2,
    parameter int DWELL   = 16
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             enable,
    input  logic             hold,
    input  logic [LED_W-1:0] SYS_leds,
    output logic [7:0]       SYS_output_sel,
    output logic             cap_valid,
    output logic [7:0]       cap_index,
    output logic [LED_W-1:0] cap_data,
    output logic [LED_W-1:0] disp_data,
    output logic             frame_done
);

    localparam logic [c_SEL_W-1:0] c_LAST_SEL  = c_SEL_W'(NUM_SEL - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LD = c_CNT_W'(SETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_LD  = c_CNT_W'(DWELL - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_SEL_W-1:0]   r_sel;
    logic [c_SEL_W-1:0]   r_cap_index;
    logic [LED_W-1:0]     r_cap_data;
    logic [LED_W-1:0]     r_disp_data;
    logic                 r_cap_valid;
    logic                 r_frame_done;

    logic w_set_load, w_set_dec, w_set_zero;
    logic w_dwl_load, w_dwl_dec, w_dwl_zero;
    logic w_capture,  w_advance;

    sys_load_counter #(.WIDTH(c_CNT_W)) u_settle_cnt (
        .i_clk      (SYS_clk),
        .i_rst_n    (SYS_reset),
        .i_load     (w_set_load),
        .i_load_val (c_SETTLE_LD),
        .i_dec      (w_set_dec),
        .o_zero     (w_set_zero)
    );

    sys_load_counter #(.WIDTH(c_CNT_W)) u_dwell_cnt (
        .i_clk      (SYS_clk),
        .i_rst_n    (SYS_reset),
        .i_load     (w_dwl_load),
        .i_load_val (c_DWELL_LD),
        .i_dec      (w_dwl_dec),
        .o_zero     (w_dwl_zero)
    );

    // Dropping enable beats hold in every active state; hold only stalls counting.
    always_comb begin
        w_state_nxt = r_state;
        w_set_load  = 1'b0;
        w_set_dec   = 1'b0;
        w_dwl_load  = 1'b0;
        w_dwl_dec   = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_SETTLE;
                    w_set_load  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (!hold) begin
                    if (w_set_zero) begin
                        w_state_nxt = ST_SAMPLE;
                    end else begin
                        w_set_dec = 1'b1;
                    end
                end
            end
            ST_SAMPLE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_capture   = 1'b1;
                    w_dwl_load  = 1'b1;
                    w_state_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (!hold) begin
                    if (w_dwl_zero) begin
                        w_advance   = 1'b1;
                        w_set_load  = 1'b1;
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_dwl_dec = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_cap_index  <= '0;
            r_cap_data   <= '0;
            r_disp_data  <= '0;
            r_cap_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cap_valid  <= w_capture;
            r_frame_done <= w_capture && (r_sel == c_LAST_SEL);
            if (w_advance) begin
                r_sel <= (r_sel == c_LAST_SEL) ? '0 : r_sel + 1'b1;
            end
            if (w_capture) begin
                r_cap_data  <= SYS_leds;
                r_cap_index <= r_sel;
                r_disp_data <= SYS_leds;
            end
        end
    end

    assign SYS_output_sel = r_sel;
    assign cap_valid      = r_cap_valid;
    assign cap_index      = r_cap_index;
    assign cap_data       = r_cap_data;
    assign disp_data      = r_disp_data;
    assign frame_done     = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sys_output_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_output_scanner
// Description : Directed, table-driven bench for the system output scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_output_scanner;

    typedef struct {
        logic [7:0]  idx;
        logic [26:0] data;
        logic        fd;
        int          gap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        hold;
    logic        led_mode;
    logic [26:0] led_const;
    logic [26:0] leds;
    logic [7:0]  sel;
    logic        cap_valid;
    logic [7:0]  cap_index;
    logic [26:0] cap_data;
    logic [26:0] disp_data;
    logic        frame_done;

    logic [26:0] leds5;
    logic [7:0]  sel5;
    logic        cap_valid5;
    logic [7:0]  cap_index5;
    logic [26:0] cap_data5;
    logic [26:0] disp_data5;
    logic        frame_done5;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int fd_cnt   = 0;

    always #5 clk = ~clk;

    assign leds  = led_mode ? {19'h0, sel} : led_const;
    assign leds5 = {19'h0, sel5};

    sys_output_scanner u_dut (
        .SYS_clk        (clk),
        .SYS_reset      (rst_n),
        .enable         (enable),
        .hold           (hold),
        .SYS_leds       (leds),
        .SYS_output_sel (sel),
        .cap_valid      (cap_valid),
        .cap_index      (cap_index),
        .cap_data       (cap_data),
        .disp_data      (disp_data),
        .frame_done     (frame_done)
    );

    sys_output_scanner #(.NUM_SEL(5), .SETTLE(1), .DWELL(1)) u_dut5 (
        .SYS_clk        (clk),
        .SYS_reset      (rst_n),
        .enable         (1'b1),
        .hold           (1'b0),
        .SYS_leds       (leds5),
        .SYS_output_sel (sel5),
        .cap_valid      (cap_valid5),
        .cap_index      (cap_index5),
        .cap_data       (cap_data5),
        .disp_data      (disp_data5),
        .frame_done     (frame_done5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_cap(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (frame_done) fd_cnt++;
        end while (!cap_valid && n < 80);
    endtask

    initial begin
        vec_t        tbl[11];
        logic [7:0]  seq_a[6];
        logic [7:0]  seq5[7];
        int          n;
        int          extra;
        logic [7:0]  prev5;

        tbl[0]  = '{8'd1, 27'd1, 1'b0, 19};
        tbl[1]  = '{8'd2, 27'd2, 1'b0, 19};
        tbl[2]  = '{8'd3, 27'd3, 1'b0, 19};
        tbl[3]  = '{8'd4, 27'd4, 1'b0, 19};
        tbl[4]  = '{8'd5, 27'd5, 1'b0, 19};
        tbl[5]  = '{8'd6, 27'd6, 1'b0, 19};
        tbl[6]  = '{8'd7, 27'd7, 1'b1, 19};
        tbl[7]  = '{8'd0, 27'd0, 1'b0, 19};
        tbl[8]  = '{8'd1, 27'd1, 1'b0, 19};
        tbl[9]  = '{8'd2, 27'd2, 1'b0, 19};
        tbl[10] = '{8'd3, 27'd3, 1'b0, 19};
        seq_a   = '{8'd7, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        seq5    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2};

        rst_n     = 1'b0;
        enable    = 1'b1;
        hold      = 1'b0;
        led_mode  = 1'b0;
        led_const = 27'h5A5A5A5;

        repeat (3) begin
            @(negedge clk);
            check("rst_sel", sel, 0);
            check("rst_disp", disp_data, 0);
            check("rst_cap_valid", cap_valid, 0);
        end

        rst_n = 1'b1;
        wait_cap(n);
        check("first_latency", n, 4);
        check("first_data", cap_data, 27'h5A5A5A5);
        check("first_index", cap_index, 0);

        led_mode = 1'b1;
        fd_cnt   = 0;
        for (int i = 0; i < 11; i++) begin
            wait_cap(n);
            check("frame_gap", n, tbl[i].gap);
            check("frame_index", cap_index, tbl[i].idx);
            check("frame_data", cap_data, tbl[i].data);
            check("frame_done", frame_done, tbl[i].fd);
        end
        check("frame_done_count", fd_cnt, 1);

        // Hold mid-dwell on select 3
        extra = 0;
        repeat (5) @(negedge clk);
        hold = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (cap_valid) extra++;
        end
        check("hold_sel", sel, 3);
        hold = 1'b0;
        wait_cap(n);
        check("hold_gap", n, 14);
        check("hold_extra", extra, 0);
        check("hold_index", cap_index, 4);

        wait_cap(n);
        check("idx5_gap", n, 19);
        check("idx5_index", cap_index, 5);

        // Enable dropped during settle on select 6
        repeat (16) @(negedge clk);
        check("pre_drop_sel", sel, 6);
        enable = 1'b0;
        @(negedge clk);
        check("drop_sel", sel, 6);
        check("drop_cap_valid", cap_valid, 0);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (cap_valid) extra++;
        end
        check("idle_sel", sel, 6);
        check("idle_disp", disp_data, 5);
        check("idle_extra", extra, 0);
        enable = 1'b1;
        wait_cap(n);
        check("reenable_latency", n, 4);
        check("reenable_index", cap_index, 6);
        check("reenable_data", cap_data, 6);

        for (int k = 0; k < 6; k++) begin
            wait_cap(n);
            check("seq_gap", n, 19);
            check("seq_index", cap_index, seq_a[k]);
        end

        // One-cycle reset mid-dwell on select 4
        repeat (5) @(negedge clk);
        check("pre_rst_sel", sel, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_sel", sel, 0);
        check("mrst_index", cap_index, 0);
        check("mrst_data", cap_data, 0);
        check("mrst_disp", disp_data, 0);
        check("mrst_cap_valid", cap_valid, 0);
        check("mrst_frame_done", frame_done, 0);
        wait_cap(n);
        check("mrst_latency", n, 4);
        check("mrst_restart_index", cap_index, 0);

        // Five-select instance: wrap at 4 back to 0
        n = 0;
        while (sel5 != 8'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sel5_find_zero", sel5, 0);
        for (int k = 0; k < 7; k++) begin
            prev5 = sel5;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (sel5 > 8'd4) check("sel5_range", sel5, 4);
            end while (sel5 == prev5 && n < 20);
            check("sel5_seq", sel5, seq5[k]);
            check("sel5_gap", n, 3);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
